// File: rtl/msk_aes_pkg.sv
// Shared constants for the masked AES input loader: block geometry and FSM encoding.
package msk_aes_pkg;

   localparam int WORD_CNT     = 8;
   localparam int PT_START_IDX = 4;
   localparam int CNT_W        = 3;

   localparam logic [0:0] ST_LOAD = 1'b0;
   localparam logic [0:0] ST_SEND = 1'b1;

   typedef logic [CNT_W-1:0] word_idx_t;

endpackage

// File: rtl/msk_word_share.sv
// Combinational d-share masking of one 32-bit word; bit j occupies [d*j +: d].
module msk_word_share #(
   parameter int d = 2
) (
   input  logic [31:0]          data_i,
   input  logic [32*(d-1)-1:0]  rnd_i,
   output logic [32*d-1:0]      share_o
);

   for (genvar gi = 0; gi < 32; gi++) begin : g_bit
      // Share 0 absorbs the XOR of all random shares so the bit recombines exactly.
      assign share_o[d*gi+1 +: d-1] = rnd_i[(d-1)*gi +: d-1];
      assign share_o[d*gi]          = data_i[gi] ^ (^rnd_i[(d-1)*gi +: d-1]);
   end

endmodule

// File: rtl/msk_aes_input_loader.sv
// Loads key then plaintext words from the host, masks them into d shares and starts the AES core.
// Optional MSK_LOADER_KEY_REUSE_EN adds in_pt_only to reload only the plaintext of a block.
module msk_aes_input_loader
   import msk_aes_pkg::*;
#(
   parameter int d = 2
) (
   input  logic                 clk,
   input  logic                 nrst,
   input  logic [31:0]          in_data,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [32*(d-1)-1:0]  rnd,
   input  logic                 rnd_valid,
   output logic                 rnd_ready,
   output logic [128*d-1:0]     sh_key,
   output logic [128*d-1:0]     sh_plaintext,
   output logic                 aes_valid_in,
   input  logic                 aes_ready,
   output logic                 busy
`ifdef MSK_LOADER_KEY_REUSE_EN
   ,
   input  logic                 in_pt_only
`endif
);

   logic [0:0]       state_q, state_d;
   word_idx_t        cnt_q, cnt_d;
   word_idx_t        slot;
   logic             accept;
   logic             pt_only;
   logic [32*d-1:0]  word_sh;
   logic [32*d-1:0]  word_q [WORD_CNT];

`ifdef MSK_LOADER_KEY_REUSE_EN
   assign pt_only = in_pt_only;
`else
   assign pt_only = 1'b0;
`endif

   msk_word_share #(.d(d)) u_share (
      .data_i  (in_data),
      .rnd_i   (rnd),
      .share_o (word_sh)
   );

   assign in_ready     = (state_q == ST_LOAD) & rnd_valid;
   assign accept       = in_valid & in_ready;
   assign rnd_ready    = accept;
   assign aes_valid_in = (state_q == ST_SEND) & aes_ready;
   assign busy         = ~((state_q == ST_LOAD) && (cnt_q == '0));

   always_comb begin
      slot    = cnt_q;
      cnt_d   = cnt_q;
      state_d = state_q;
      // A plaintext-only block starts directly at plaintext word 0, leaving the key words alone.
      if (pt_only && (cnt_q == '0)) begin
         slot = word_idx_t'(PT_START_IDX);
      end
      case (state_q)
         ST_LOAD: begin
            if (accept) begin
               cnt_d = slot + word_idx_t'(1);
               if (slot == word_idx_t'(WORD_CNT - 1)) begin
                  state_d = ST_SEND;
               end
            end
         end
         default: begin
            if (aes_ready) begin
               state_d = ST_LOAD;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         state_q <= ST_LOAD;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < WORD_CNT; i++) begin
         if (!nrst) begin
            word_q[i] <= '0;
         end else if (accept && (slot == word_idx_t'(i))) begin
            word_q[i] <= word_sh;
         end
      end
   end

   for (genvar gi = 0; gi < PT_START_IDX; gi++) begin : g_out
      assign sh_key[32*d*gi +: 32*d]       = word_q[gi];
      assign sh_plaintext[32*d*gi +: 32*d] = word_q[gi + PT_START_IDX];
   end

endmodule

// File: tb/tb_msk_aes_input_loader.sv
// Randomized self-checking bench for msk_aes_input_loader against a word-level reference model.
module tb_msk_aes_input_loader;

   localparam int D  = 2;
   localparam int WW = 32 * D;

   logic                 clk = 1'b0;
   logic                 nrst;
   logic [31:0]          in_data;
   logic                 in_valid;
   logic                 in_ready;
   logic [32*(D-1)-1:0]  rnd;
   logic                 rnd_valid;
   logic                 rnd_ready;
   logic [128*D-1:0]     sh_key;
   logic [128*D-1:0]     sh_plaintext;
   logic                 aes_valid_in;
   logic                 aes_ready;
   logic                 busy;
`ifdef MSK_LOADER_KEY_REUSE_EN
   logic                 in_pt_only;
`endif

   always #5 clk = ~clk;

   msk_aes_input_loader #(.d(D)) dut (
      .clk          (clk),
      .nrst         (nrst),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .rnd          (rnd),
      .rnd_valid    (rnd_valid),
      .rnd_ready    (rnd_ready),
      .sh_key       (sh_key),
      .sh_plaintext (sh_plaintext),
      .aes_valid_in (aes_valid_in),
      .aes_ready    (aes_ready),
      .busy         (busy)
`ifdef MSK_LOADER_KEY_REUSE_EN
      ,
      .in_pt_only   (in_pt_only)
`endif
   );

   int total = 0;
   int bad   = 0;

   // Reference model: which words have been received, where the next one goes, whether a block waits.
   logic [WW-1:0] m_words [8];
   int            m_idx;
   bit            m_send;
   int            exp_pulses;
   int            obs_pulses;
   int            accepts;

   logic [31:0] key_w [4] = '{32'h16157e2b, 32'ha6d2ae28, 32'h8815f7ab, 32'h3c4fcf09};
   logic [31:0] pt_w  [4] = '{32'ha8f64332, 32'h8d305a88, 32'ha2983131, 32'h340737e0};

   task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [WW-1:0] share_word(input logic [31:0] w, input logic [32*(D-1)-1:0] r);
      logic [WW-1:0] v;
      logic          x;
      v = '0;
      for (int j = 0; j < 32; j++) begin
         x = w[j];
         for (int s = 1; s < D; s++) begin
            v[D*j+s] = r[(D-1)*j + s - 1];
            x        = x ^ r[(D-1)*j + s - 1];
         end
         v[D*j] = x;
      end
      return v;
   endfunction

   function automatic logic [127:0] recombine(input logic [128*D-1:0] v);
      logic [127:0] u;
      u = '0;
      for (int i = 0; i < 128; i++) begin
         for (int s = 0; s < D; s++) u[i] = u[i] ^ v[D*i+s];
      end
      return u;
   endfunction

   function automatic logic [127:0] words128(input logic [31:0] w0, input logic [31:0] w1,
                                              input logic [31:0] w2, input logic [31:0] w3);
      return {w3, w2, w1, w0};
   endfunction

   function automatic logic [32*(D-1)-1:0] rand_rnd();
      logic [32*(D-1)-1:0] r;
      for (int k = 0; k < D-1; k++) r[32*k +: 32] = $urandom;
      return r;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_words[i] = '0;
      m_idx  = 0;
      m_send = 0;
   endtask

   task automatic step(input bit iv, input bit rv, input logic [31:0] dat,
                       input logic [32*(D-1)-1:0] r, input bit ar, input bit pto);
      bit exp_ir;
      int slot;
      @(negedge clk);
      in_valid  = iv;
      rnd_valid = rv;
      in_data   = dat;
      rnd       = r;
      aes_ready = ar;
`ifdef MSK_LOADER_KEY_REUSE_EN
      in_pt_only = pto;
`endif
      #1;
      exp_ir = !m_send && rv;
      check("in_ready", in_ready, exp_ir);
      check("rnd_ready", rnd_ready, iv && exp_ir);
      check("aes_valid_in", aes_valid_in, m_send && ar);
      check("busy", busy, m_send || (m_idx != 0));
      check("sh_key", sh_key, {m_words[3], m_words[2], m_words[1], m_words[0]});
      check("sh_plaintext", sh_plaintext, {m_words[7], m_words[6], m_words[5], m_words[4]});
      if (aes_valid_in) obs_pulses++;
      if (iv && exp_ir) begin
         accepts++;
         slot = m_idx;
         if (pto && m_idx == 0) slot = 4;
         m_words[slot] = share_word(dat, r);
         if (slot == 7) begin
            m_send = 1;
            m_idx  = 0;
         end else begin
            m_idx = slot + 1;
         end
      end else if (m_send && ar) begin
         m_send = 0;
         exp_pulses++;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      nrst      = 1'b0;
      in_valid  = 1'b0;
      rnd_valid = 1'b0;
      aes_ready = 1'b0;
      @(negedge clk);
      nrst = 1'b1;
      model_reset();
   endtask

   task automatic load_block(input bit rand_rnd_en);
      for (int k = 0; k < 8; k++) begin
         step(1'b1, 1'b1, (k < 4) ? key_w[k] : pt_w[k-4],
              rand_rnd_en ? rand_rnd() : '0, 1'b0, 1'b0);
      end
   endtask

   initial begin
      logic [127:0] saved_key;
      int           cyc;
      nrst       = 1'b0;
      in_valid   = 1'b0;
      in_data    = '0;
      rnd        = '0;
      rnd_valid  = 1'b0;
      aes_ready  = 1'b0;
`ifdef MSK_LOADER_KEY_REUSE_EN
      in_pt_only = 1'b0;
`endif
      exp_pulses = 0;
      obs_pulses = 0;
      accepts    = 0;
      model_reset();
      do_reset();

      // Reset state, with randomness offered but no host word.
      step(1'b0, 1'b1, 32'h0, '0, 1'b0, 1'b0);

      // Known vector with all-zero randomness: share 0 carries the plain words.
      load_block(1'b0);
      @(posedge clk); #1;
      check("zero_rnd_key", recombine(sh_key), words128(key_w[0], key_w[1], key_w[2], key_w[3]));
      check("zero_rnd_pt", recombine(sh_plaintext), words128(pt_w[0], pt_w[1], pt_w[2], pt_w[3]));
      check("zero_rnd_key_val", recombine(sh_key), 128'h3c4fcf098815f7aba6d2ae2816157e2b);
      step(1'b0, 1'b0, 32'h0, '0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 32'h0, '0, 1'b1, 1'b0);
      check("pulses_a", obs_pulses, exp_pulses);

      // Same words with fresh randomness must still recombine to the unmasked block.
      load_block(1'b1);
      @(posedge clk); #1;
      check("rand_rnd_key", recombine(sh_key), 128'h3c4fcf098815f7aba6d2ae2816157e2b);
      check("rand_rnd_pt", recombine(sh_plaintext), 128'h340737e0a29831318d305a88a8f64332);
      step(1'b0, 1'b0, 32'h0, '0, 1'b1, 1'b0);
      check("pulses_b", obs_pulses, exp_pulses);

      // rnd_valid low every other cycle, host valid random.
      accepts = 0;
      cyc = 0;
      while (!m_send && cyc < 200) begin
         step($urandom_range(0, 3) != 0, cyc[0], $urandom, rand_rnd(), 1'b0, 1'b0);
         cyc++;
      end
      check("toggle_reached_send", m_send, 1'b1);
      check("toggle_accepts", accepts, 8);

      // Core not ready for 10 cycles: hold SEND, then exactly one pulse.
      for (int k = 0; k < 10; k++) step($urandom_range(0, 1), 1'b1, $urandom, rand_rnd(), 1'b0, 1'b0);
      check("pulses_held", obs_pulses, exp_pulses);
      for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 32'h0, '0, 1'b1, 1'b0);
      check("pulses_c", obs_pulses, exp_pulses);
      check("one_pulse_total", obs_pulses, 3);

      // Reset after 5 accepts drops the partial block.
      for (int k = 0; k < 5; k++) step(1'b1, 1'b1, $urandom, rand_rnd(), 1'b0, 1'b0);
      do_reset();
      for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 32'h0, '0, 1'b1, 1'b0);
      check("reset_no_pulse", obs_pulses, 3);
      check("reset_key_zero", sh_key, '0);

`ifdef MSK_LOADER_KEY_REUSE_EN
      // Full block, then a plaintext-only block of 4 words with the key left in place.
      load_block(1'b1);
      step(1'b0, 1'b0, 32'h0, '0, 1'b1, 1'b0);
      @(posedge clk); #1;
      saved_key = recombine(sh_key);
      for (int k = 0; k < 4; k++) step(1'b1, 1'b1, $urandom, rand_rnd(), 1'b0, k == 0);
      check("reuse_in_send", m_send, 1'b1);
      step(1'b0, 1'b0, 32'h0, '0, 1'b1, 1'b0);
      @(posedge clk); #1;
      check("reuse_key_kept", recombine(sh_key), saved_key);
      check("reuse_pulses", obs_pulses, exp_pulses);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
